// File: rtl/cpu_load_store_unit_if.sv
// Bus between the load/store unit and data memory: request/ready handshake
// with a separate read-data return qualified by bus_rvalid.
interface cpu_load_store_unit_if #(
   parameter int BITS         = 16,
   parameter int ADDRESS_BITS = 16
);
   localparam int LANES = BITS / 8;

   logic                    bus_valid;
   logic                    bus_ready;
   logic                    bus_we;
   logic [ADDRESS_BITS-1:0] bus_addr;
   logic [BITS-1:0]         bus_wdata;
   logic [LANES-1:0]        bus_wmask;
   logic [BITS-1:0]         bus_rdata;
   logic                    bus_rvalid;

   modport master (
      output bus_valid, bus_we, bus_addr, bus_wdata, bus_wmask,
      input  bus_ready, bus_rdata, bus_rvalid
   );

   modport slave (
      input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wmask,
      output bus_ready, bus_rdata, bus_rvalid
   );
endinterface

// File: rtl/cpu_load_store_unit.sv
// Load/store unit: posted stores through a small FIFO, blocking loads that
// wait for the store buffer to drain before issuing a bus read.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accepting requests; FIFO head drained to the bus if present
// DRAIN   | load captured, still emptying posted stores ahead of it
// LD_ADDR | read request on the bus, waiting for bus_ready
// LD_DATA | read accepted, waiting for bus_rvalid
module cpu_load_store_unit #(
   parameter int BITS         = 16,
   parameter int ADDRESS_BITS = 16,
   parameter int STORE_DEPTH  = 2
) (
   input  logic                         CLK,
   input  logic                         RSTb,
   input  logic                         load_req,
   input  logic                         store_req,
   input  logic                         byte_op,
   input  logic [ADDRESS_BITS-1:0]      addr,
   input  logic [BITS-1:0]              wdata,
   output logic                         stall,
   output logic [BITS-1:0]              load_data,
   output logic                         load_valid,
   output logic [$clog2(STORE_DEPTH):0] store_count,
   cpu_load_store_unit_if.master        bus
);

   localparam int LANES = BITS / 8;
   localparam int LB    = $clog2(LANES);
   localparam int CW    = $clog2(STORE_DEPTH) + 1;
   localparam int PW    = (STORE_DEPTH > 1) ? $clog2(STORE_DEPTH) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DRAIN   = 2'd1;
   localparam logic [1:0] S_LD_ADDR = 2'd2;
   localparam logic [1:0] S_LD_DATA = 2'd3;

   logic [1:0]              state;
   logic [CW-1:0]           count;
   logic [CW-1:0]           count_next;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;

   logic [ADDRESS_BITS-1:0] fifo_addr  [STORE_DEPTH];
   logic [BITS-1:0]         fifo_data  [STORE_DEPTH];
   logic [LANES-1:0]        fifo_mask  [STORE_DEPTH];

   logic [ADDRESS_BITS-1:0] ld_addr;
   logic [LB-1:0]           ld_lane;
   logic                    ld_byte;

   logic                    push;
   logic                    pop;
   logic                    load_acc;
   logic                    fifo_on_bus;
   logic [LB-1:0]           lane;
   logic [ADDRESS_BITS-1:0] word_addr;
   logic [BITS-1:0]         st_data;
   logic [LANES-1:0]        st_mask;
   logic [BITS-1:0]         rd_shift;
   logic [BITS-1:0]         rd_result;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(STORE_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign lane      = addr[LB-1:0];
   assign word_addr = addr >> LB;
   assign st_data   = byte_op ? ({{(BITS-8){1'b0}}, wdata[7:0]} << {lane, 3'b000}) : wdata;
   assign st_mask   = byte_op ? (LANES'(1) << lane) : {LANES{1'b1}};

   // A pop in the same cycle does not free a slot for a waiting store.
   assign stall    = (state != S_IDLE) | (store_req & (count == CW'(STORE_DEPTH)));
   assign push     = store_req & ~stall;
   assign load_acc = load_req & ~store_req & ~stall;

   assign fifo_on_bus = ((state == S_IDLE) || (state == S_DRAIN)) && (count != '0);
   assign pop         = fifo_on_bus & bus.bus_ready;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + CW'(1);
      else if (pop && !push)
         count_next = count - CW'(1);
   end

   assign store_count = count;

   always_comb begin
      bus.bus_valid = 1'b0;
      bus.bus_we    = 1'b0;
      bus.bus_addr  = '0;
      bus.bus_wdata = '0;
      bus.bus_wmask = '0;
      if (state == S_LD_ADDR) begin
         bus.bus_valid = 1'b1;
         bus.bus_addr  = ld_addr;
      end else if (fifo_on_bus) begin
         bus.bus_valid = 1'b1;
         bus.bus_we    = 1'b1;
         bus.bus_addr  = fifo_addr[rd_ptr];
         bus.bus_wdata = fifo_data[rd_ptr];
         bus.bus_wmask = fifo_mask[rd_ptr];
      end
   end

   assign rd_shift  = bus.bus_rdata >> {ld_lane, 3'b000};
   assign rd_result = ld_byte ? {{(BITS-8){1'b0}}, rd_shift[7:0]} : bus.bus_rdata;

   // Storage needs no reset: entries are only visible when count says so.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_addr[wr_ptr] <= word_addr;
         fifo_data[wr_ptr] <= st_data;
         fifo_mask[wr_ptr] <= st_mask;
      end
   end

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         count <= count_next;
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
      end
   end

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         state      <= S_IDLE;
         ld_addr    <= '0;
         ld_lane    <= '0;
         ld_byte    <= 1'b0;
         load_data  <= '0;
         load_valid <= 1'b0;
      end else begin
         load_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (load_acc) begin
                  ld_addr <= word_addr;
                  ld_lane <= lane;
                  ld_byte <= byte_op;
                  state   <= (count_next != '0) ? S_DRAIN : S_LD_ADDR;
               end
            end
            S_DRAIN: begin
               if (count_next == '0)
                  state <= S_LD_ADDR;
            end
            S_LD_ADDR: begin
               if (bus.bus_ready)
                  state <= S_LD_DATA;
            end
            S_LD_DATA: begin
               if (bus.bus_rvalid) begin
                  load_data  <= rd_result;
                  load_valid <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_load_store_unit.sv
// Scoreboard bench for cpu_load_store_unit: a 16-bit instance for most
// scenarios and a 32-bit instance for wide-word byte lanes.
module tb_cpu_load_store_unit;

   logic CLK = 1'b0;
   logic RSTb;
   always #5 CLK = ~CLK;

   logic        load_req, store_req, byte_op;
   logic [15:0] addr, wdata;
   logic        stall;
   logic [15:0] load_data;
   logic        load_valid;
   logic [1:0]  store_count;

   cpu_load_store_unit_if #(.BITS(16), .ADDRESS_BITS(16)) bus ();
   cpu_load_store_unit #(.BITS(16), .ADDRESS_BITS(16), .STORE_DEPTH(2)) u_dut (
      .CLK(CLK), .RSTb(RSTb), .load_req(load_req), .store_req(store_req),
      .byte_op(byte_op), .addr(addr), .wdata(wdata), .stall(stall),
      .load_data(load_data), .load_valid(load_valid),
      .store_count(store_count), .bus(bus));

   logic        l32_req, s32_req, b32_op;
   logic [15:0] a32;
   logic [31:0] w32;
   logic        stall32;
   logic [31:0] ld32;
   logic        lv32;
   logic [1:0]  cnt32;

   cpu_load_store_unit_if #(.BITS(32), .ADDRESS_BITS(16)) bus32 ();
   cpu_load_store_unit #(.BITS(32), .ADDRESS_BITS(16), .STORE_DEPTH(2)) u_dut32 (
      .CLK(CLK), .RSTb(RSTb), .load_req(l32_req), .store_req(s32_req),
      .byte_op(b32_op), .addr(a32), .wdata(w32), .stall(stall32),
      .load_data(ld32), .load_valid(lv32),
      .store_count(cnt32), .bus(bus32));

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } bus_t;

   bus_t        exp_q[$];
   bus_t        exp32_q[$];
   logic [31:0] ld_q[$];
   logic [31:0] ld32_q[$];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          lv_count = 0;
   int          lv32_count = 0;
   int          rd_delay = 1;
   logic [15:0] rd_value = 16'h0;

   function automatic bus_t mk(input logic we, input logic [15:0] a,
                               input logic [31:0] d, input logic [3:0] m);
      bus_t t;
      t.we = we; t.addr = a; t.wdata = d; t.mask = m;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] a);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got event with value 0x%0h, expected none", name, a);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // 16-bit memory model + scoreboard monitor
   int   rcnt;
   logic hs_rd;
   logic p_valid, p_ready;
   bus_t p_txn, e_txn;

   initial begin
      rcnt = 0; p_valid = 1'b0; p_ready = 1'b0;
      bus.bus_rvalid = 1'b0;
      bus.bus_rdata  = 16'h0;
      forever begin
         @(negedge CLK);
         hs_rd = 1'b0;
         if (!RSTb) begin
            p_valid = 1'b0;
            rcnt    = 0;
         end else begin
            if (p_valid && !p_ready) begin
               check("hold_valid", bus.bus_valid, 1'b1);
               check("hold_we", bus.bus_we, p_txn.we);
               check("hold_addr", bus.bus_addr, p_txn.addr);
               check("hold_wdata", bus.bus_wdata, p_txn.wdata);
               check("hold_wmask", bus.bus_wmask, p_txn.mask);
            end
            if (bus.bus_valid && bus.bus_ready) begin
               if (exp_q.size() == 0)
                  unexpected("bus_txn", {15'h0, bus.bus_we, bus.bus_addr});
               else begin
                  e_txn = exp_q.pop_front();
                  check("bus_we", bus.bus_we, e_txn.we);
                  check("bus_addr", bus.bus_addr, e_txn.addr);
                  check("bus_wdata", bus.bus_wdata, e_txn.wdata);
                  check("bus_wmask", bus.bus_wmask, e_txn.mask);
                  hs_rd = !bus.bus_we;
               end
            end
            p_valid     = bus.bus_valid;
            p_ready     = bus.bus_ready;
            p_txn.we    = bus.bus_we;
            p_txn.addr  = bus.bus_addr;
            p_txn.wdata = 32'(bus.bus_wdata);
            p_txn.mask  = 4'(bus.bus_wmask);
            if (load_valid) begin
               lv_count++;
               if (ld_q.size() == 0)
                  unexpected("load_valid", 32'(load_data));
               else
                  check("load_data", load_data, ld_q.pop_front());
            end
         end
         @(posedge CLK);
         #1;
         if (hs_rd)
            rcnt = rd_delay;
         if (rcnt > 0) begin
            rcnt--;
            bus.bus_rvalid = (rcnt == 0);
            bus.bus_rdata  = (rcnt == 0) ? rd_value : 16'h0;
         end else begin
            bus.bus_rvalid = 1'b0;
            bus.bus_rdata  = 16'h0;
         end
      end
   end

   // 32-bit memory model: always ready, rdata fixed, rvalid one cycle after read
   logic hs32;
   bus_t e32;

   initial begin
      bus32.bus_ready  = 1'b1;
      bus32.bus_rvalid = 1'b0;
      bus32.bus_rdata  = 32'hDEADBEEF;
      forever begin
         @(negedge CLK);
         hs32 = 1'b0;
         if (RSTb && bus32.bus_valid && bus32.bus_ready) begin
            if (exp32_q.size() == 0)
               unexpected("bus32_txn", {15'h0, bus32.bus_we, bus32.bus_addr});
            else begin
               e32 = exp32_q.pop_front();
               check("bus32_we", bus32.bus_we, e32.we);
               check("bus32_addr", bus32.bus_addr, e32.addr);
               check("bus32_wdata", bus32.bus_wdata, e32.wdata);
               check("bus32_wmask", bus32.bus_wmask, e32.mask);
               hs32 = !bus32.bus_we;
            end
         end
         if (RSTb && lv32) begin
            lv32_count++;
            if (ld32_q.size() == 0)
               unexpected("load_valid32", ld32);
            else
               check("load_data32", ld32, ld32_q.pop_front());
         end
         @(posedge CLK);
         #1;
         bus32.bus_rvalid = hs32;
      end
   end

   task automatic wait_no_stall(input string name);
      int guard;
      guard = 0;
      #1;
      while (stall && guard < 50) begin
         tick();
         #1;
         guard++;
      end
      if (stall)
         check({name, "_timeout"}, stall, 1'b0);
   endtask

   task automatic do_store(input logic bop, input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] ea, input logic [15:0] ed, input logic [1:0] em);
      store_req = 1'b1; byte_op = bop; addr = a; wdata = d;
      wait_no_stall("store_accept");
      exp_q.push_back(mk(1'b1, ea, 32'(ed), 4'(em)));
      tick();
      store_req = 1'b0; byte_op = 1'b0;
   endtask

   task automatic wait_load(input string name);
      int lv0;
      lv0 = lv_count;
      for (int i = 0; i < 60; i++) begin
         if (load_valid) break;
         check({name, "_stall_busy"}, stall, 1'b1);
         tick();
      end
      check({name, "_valid"}, load_valid, 1'b1);
      check({name, "_stall_release"}, stall, 1'b0);
      tick();
      check({name, "_pulse_end"}, load_valid, 1'b0);
      check({name, "_once"}, lv_count, lv0 + 1);
   endtask

   task automatic do_load(input logic bop, input logic [15:0] a, input logic [15:0] ea,
                          input logic [15:0] rv, input logic [15:0] el);
      rd_value = rv; load_req = 1'b1; byte_op = bop; addr = a;
      wait_no_stall("load_accept");
      exp_q.push_back(mk(1'b0, ea, 32'h0, 4'h0));
      ld_q.push_back(32'(el));
      tick();
      load_req = 1'b0; byte_op = 1'b0;
      wait_load("load");
   endtask

   int lv0;

   initial begin
      RSTb = 1'b0;
      load_req = 1'b0; store_req = 1'b0; byte_op = 1'b0; addr = '0; wdata = '0;
      l32_req = 1'b0; s32_req = 1'b0; b32_op = 1'b0; a32 = '0; w32 = '0;
      bus.bus_ready = 1'b0;
      repeat (2) tick();
      check("rst_stall", stall, 1'b0);
      check("rst_load_valid", load_valid, 1'b0);
      check("rst_load_data", load_data, 16'h0);
      check("rst_bus_valid", bus.bus_valid, 1'b0);
      check("rst_bus_we", bus.bus_we, 1'b0);
      check("rst_bus_addr", bus.bus_addr, 16'h0);
      check("rst_bus_wdata", bus.bus_wdata, 16'h0);
      check("rst_bus_wmask", bus.bus_wmask, 2'b00);
      check("rst_store_count", store_count, 2'd0);
      RSTb = 1'b1;
      tick();

      // byte store, lane 1, visible the cycle after acceptance
      bus.bus_ready = 1'b1;
      do_store(1'b1, 16'h0011, 16'h12AB, 16'h0008, 16'hAB00, 2'b10);
      check("bst_bus_valid", bus.bus_valid, 1'b1);
      check("bst_bus_addr", bus.bus_addr, 16'h0008);
      check("bst_bus_wdata", bus.bus_wdata, 16'hAB00);
      check("bst_bus_wmask", bus.bus_wmask, 2'b10);
      check("bst_count", store_count, 2'd1);
      do_store(1'b0, 16'h0013, 16'hBEEF, 16'h0009, 16'hBEEF, 2'b11);
      do_store(1'b1, 16'h0020, 16'h5577, 16'h0010, 16'h0077, 2'b01);
      repeat (2) tick();
      check("stores_drained", store_count, 2'd0);

      // word load, empty FIFO, zero wait states: exact cycle timing
      rd_delay = 1; rd_value = 16'h9876;
      load_req = 1'b1; addr = 16'h0A02; #1;
      check("ld_stall_N", stall, 1'b0);
      exp_q.push_back(mk(1'b0, 16'h0501, 32'h0, 4'h0));
      ld_q.push_back(32'h9876);
      tick();
      load_req = 1'b0;
      check("ld_N1_bus_valid", bus.bus_valid, 1'b1);
      check("ld_N1_bus_we", bus.bus_we, 1'b0);
      check("ld_N1_bus_addr", bus.bus_addr, 16'h0501);
      check("ld_N1_stall", stall, 1'b1);
      tick();
      check("ld_N2_bus_valid", bus.bus_valid, 1'b0);
      check("ld_N2_stall", stall, 1'b1);
      check("ld_N2_load_valid", load_valid, 1'b0);
      tick();
      check("ld_N3_load_valid", load_valid, 1'b1);
      check("ld_N3_stall", stall, 1'b0);
      check("ld_N3_load_data", load_data, 16'h9876);
      tick();
      check("ld_N4_load_valid", load_valid, 1'b0);

      // byte loads, lane 1 with rvalid delay, then lane 0
      rd_delay = 3;
      do_load(1'b1, 16'h0007, 16'h0003, 16'hCAFE, 16'h00CA);
      rd_delay = 1;
      do_load(1'b1, 16'h0008, 16'h0004, 16'hCAFE, 16'h00FE);

      // FIFO full with bus stalled
      bus.bus_ready = 1'b0;
      do_store(1'b0, 16'h0100, 16'h1111, 16'h0080, 16'h1111, 2'b11);
      do_store(1'b1, 16'h0103, 16'h0022, 16'h0081, 16'h2200, 2'b10);
      store_req = 1'b1; byte_op = 1'b0; addr = 16'h0104; wdata = 16'h3333; #1;
      check("full_stall", stall, 1'b1);
      check("full_count", store_count, 2'd2);
      repeat (2) tick();
      check("full_stall_hold", stall, 1'b1);
      bus.bus_ready = 1'b1; #1;
      check("full_stall_pop_cycle", stall, 1'b1);
      tick();
      check("full_count_after_pop", store_count, 2'd1);
      check("full_third_accept", stall, 1'b0);
      exp_q.push_back(mk(1'b1, 16'h0082, 32'h3333, 4'b0011));
      tick();
      store_req = 1'b0;
      for (int i = 0; i < 20 && store_count != 2'd0; i++) tick();
      check("full_drained", store_count, 2'd0);

      // load behind stores, bus ready, rvalid two cycles after ready
      rd_delay = 2;
      do_store(1'b0, 16'h0050, 16'hA5A5, 16'h0028, 16'hA5A5, 2'b11);
      do_store(1'b1, 16'h0051, 16'h00C3, 16'h0028, 16'hC300, 2'b10);
      do_load(1'b0, 16'h0040, 16'h0020, 16'h4242, 16'h4242);

      // load behind a full FIFO with the bus stalled for a few cycles
      rd_delay = 1;
      bus.bus_ready = 1'b0;
      do_store(1'b0, 16'h0200, 16'h0102, 16'h0100, 16'h0102, 2'b11);
      do_store(1'b1, 16'h0205, 16'h00EE, 16'h0102, 16'hEE00, 2'b10);
      fork
         begin
            repeat (3) tick();
            bus.bus_ready = 1'b1;
         end
      join_none
      do_load(1'b0, 16'h0300, 16'h0180, 16'h0BAD, 16'h0BAD);

      // simultaneous load and store: store wins, load dropped
      bus.bus_ready = 1'b1;
      lv0 = lv_count;
      store_req = 1'b1; load_req = 1'b1; byte_op = 1'b0;
      addr = 16'h0062; wdata = 16'h7777; #1;
      check("simul_stall", stall, 1'b0);
      exp_q.push_back(mk(1'b1, 16'h0031, 32'h7777, 4'b0011));
      tick();
      store_req = 1'b0; load_req = 1'b0;
      repeat (5) tick();
      check("simul_no_load_valid", lv_count, lv0);
      check("simul_write_issued", exp_q.size(), 0);
      check("simul_stall_after", stall, 1'b0);

      // reset with stores pending
      bus.bus_ready = 1'b0;
      do_store(1'b0, 16'h0400, 16'h4444, 16'h0200, 16'h4444, 2'b11);
      do_store(1'b0, 16'h0402, 16'h5555, 16'h0201, 16'h5555, 2'b11);
      check("rstp_count_before", store_count, 2'd2);
      check("rstp_valid_before", bus.bus_valid, 1'b1);
      #1 RSTb = 1'b0;
      #1;
      check("rstp_bus_valid", bus.bus_valid, 1'b0);
      check("rstp_count", store_count, 2'd0);
      exp_q.delete();
      tick();
      RSTb = 1'b1;
      bus.bus_ready = 1'b1;
      repeat (6) tick();
      check("rstp_idle_valid", bus.bus_valid, 1'b0);
      check("rstp_idle_count", store_count, 2'd0);

      // 32-bit instance: byte store lane 3, byte load lane 2, word load
      s32_req = 1'b1; b32_op = 1'b1; a32 = 16'h0007; w32 = 32'h0000005A; #1;
      check("s32_stall", stall32, 1'b0);
      exp32_q.push_back(mk(1'b1, 16'h0001, 32'h5A000000, 4'b1000));
      tick();
      s32_req = 1'b0; b32_op = 1'b0;
      tick();
      lv0 = lv32_count;
      l32_req = 1'b1; b32_op = 1'b1; a32 = 16'h0006; #1;
      check("l32_stall", stall32, 1'b0);
      exp32_q.push_back(mk(1'b0, 16'h0001, 32'h0, 4'h0));
      ld32_q.push_back(32'h000000AD);
      tick();
      l32_req = 1'b0; b32_op = 1'b0;
      repeat (4) tick();
      check("l32_byte_once", lv32_count, lv0 + 1);
      check("l32_stall_after", stall32, 1'b0);
      l32_req = 1'b1; a32 = 16'h0008; #1;
      exp32_q.push_back(mk(1'b0, 16'h0002, 32'h0, 4'h0));
      ld32_q.push_back(32'hDEADBEEF);
      tick();
      l32_req = 1'b0;
      repeat (4) tick();
      check("l32_word_once", lv32_count, lv0 + 2);

      check("bus_q_empty", exp_q.size(), 0);
      check("ld_q_empty", ld_q.size(), 0);
      check("bus32_q_empty", exp32_q.size(), 0);
      check("ld32_q_empty", ld32_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cpu_load_store_unit.md
# cpu_load_store_unit

Parametrised load/store unit that follows the execute stage and replaces its single-cycle memory strobes with a buffered, handshaked bus master. Stores are posted into a STORE_DEPTH-entry FIFO and drained in order. Loads stall the pipeline until the store buffer is empty and the read data has returned. Byte lane selection, write masks and byte-load extraction are generalised to any BITS that is a multiple of 8.

## Interface
- BITS, 16: data word width; multiple of 8, at least 16.
- ADDRESS_BITS, 16: byte-address width of `addr` and word-address width of `bus_addr`.
- STORE_DEPTH, 2: posted-store FIFO entries; power of 2, range 1..8.
- Derived: LANES = BITS/8; LB = log2(LANES); CW = log2(STORE_DEPTH)+1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTb  in  1  reset; asynchronous, active-low.
- load_req  in  1  load request from execute.
- store_req  in  1  store request from execute.
- byte_op  in  1  1 = byte access, 0 = full-word access.
- addr  in  ADDRESS_BITS  byte address of the access.
- wdata  in  BITS  store data; for byte stores only wdata[7:0] is used.
- stall  out  1  request not accepted this cycle; the pipeline holds.
- load_data  out  BITS  load result; byte loads are zero-extended.
- load_valid  out  1  one-cycle pulse qualifying `load_data`.
- store_count  out  CW  current FIFO occupancy.
- bus_valid  out  1  bus request valid.
- bus_ready  in  1  bus accepts the request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDRESS_BITS  word address, equal to addr >> LB.
- bus_wdata  out  BITS  write data.
- bus_wmask  out  LANES  per-byte write enable.
- bus_rdata  in  BITS  read data.
- bus_rvalid  in  1  read data valid.

## Operation
- Lane = addr[LB-1:0]; word address = addr >> LB.
- Word store: mask all ones; data = wdata. Lane bits of addr are ignored.
- Byte store: mask = 1 << lane; data = wdata[7:0] << (8·lane), zero elsewhere.
- A store is accepted when store_req=1 and stall=0. It is pushed as {word addr, data, mask}.
- A load is accepted when load_req=1, store_req=0 and stall=0. Its address, lane and byte_op are captured.
- load_req and store_req high together: the store is accepted and the load is dropped.
- stall = (state != IDLE) | (store_req & store_count == STORE_DEPTH).
  - A store presented while the FIFO is full waits even if a pop happens in the same cycle.
- Store drain: in IDLE and DRAIN, when the FIFO is non-empty, the FIFO head is presented with bus_valid=1 and bus_we=1. It is popped on bus_valid & bus_ready.
- FSM:
  - IDLE: on load accept, go to DRAIN if the FIFO is non-empty after this edge, else go to LD_ADDR.
  - DRAIN: when the FIFO becomes empty (last pop), go to LD_ADDR.
  - LD_ADDR: bus_valid=1, bus_we=0, bus_addr = captured word address, mask 0. On bus_ready, go to LD_DATA.
  - LD_DATA: bus_valid=0. On bus_rvalid, register the data into load_data and go to IDLE.
- Load result: word load returns bus_rdata. Byte load returns {zeros, bus_rdata[8·lane+7 : 8·lane]}.
- bus_rvalid outside LD_DATA is ignored.
- Bus hold rule: while bus_valid=1 and bus_ready=0, bus_addr, bus_wdata, bus_wmask and bus_we stay stable.
- When bus_valid=0, bus_addr, bus_wdata and bus_wmask are driven to 0.

## Timing
- Reset values: state IDLE, FIFO empty, store_count 0, stall 0, load_valid 0, load_data 0, bus_valid 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_wmask 0.
- Reset asserted mid-operation clears everything immediately. Posted stores are discarded and an outstanding load is abandoned.
- A store accepted at edge N is first visible on the bus in cycle N+1, provided the FIFO was empty.
- Load with empty FIFO, zero wait states (accepted edge N, ready in cycle N+1, rvalid in cycle N+2):
  - bus_valid is high in cycle N+1.
  - load_valid pulses in cycle N+3.
  - stall is high in cycles N+1..N+2 and low in N+3.
- Each bus_ready=0 cycle and each cycle of rvalid delay adds exactly one cycle of latency.
- Throughput: one store pop per cycle while bus_ready=1. store_count reflects push and pop from the same edge; a simultaneous push and pop leaves it unchanged.

## Test plan
- Reset with stores pending:
  - Stimulus: push 2 stores with bus_ready=0, then pulse RSTb low.
  - Required: bus_valid drops asynchronously, store_count=0, and nothing is issued after reset is released.
- Byte store, BITS=16:
  - Stimulus: store_req, byte_op=1, addr=0x0011, wdata=0x12AB.
  - Required: bus_addr=0x0008, bus_wdata=0xAB00, bus_wmask=2'b10.
- Byte load, BITS=32:
  - Stimulus: byte load at addr=0x0006, bus_rdata=0xDEADBEEF.
  - Required: load_data=0x000000AD, load_valid pulses once.
- FIFO full, STORE_DEPTH=2, bus_ready=0:
  - Stimulus: 3 back-to-back stores.
  - Required: the third stall=1, store_count=2. When bus_ready=1, stores issue in order and the third is accepted the cycle after count drops to 1.
- Load behind stores:
  - Stimulus: 2 stores, then a word load at addr 0x0040, with bus_ready=1 and rvalid 2 cycles after ready.
  - Required: both writes precede the read at bus_addr=0x0020, stall stays high throughout, and load_valid pulses exactly once.
- Simultaneous load_req and store_req:
  - Required: only a write is issued, no read occurs, and load_valid stays 0.
